// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/RUN/HALT sequencer, one-cycle fetch latency, stall, branch redirect.
// Define INSTR_FETCH_BRANCH_LUT_EN for a 16-entry branch target table; otherwise branches are pc_out-relative.
module instr_fetch #(
  parameter int                     PC_WIDTH    = 10,
  parameter int                     INSTR_WIDTH = 9,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = {INSTR_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [3:0]             target_idx,
  input  logic                   lut_we,
  input  logic [3:0]             lut_waddr,
  input  logic [PC_WIDTH-1:0]    lut_wdata,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                 state, state_nxt;
  logic [PC_WIDTH-1:0]    pc, pc_nxt, pc_out_nxt, target;
  logic [INSTR_WIDTH-1:0] instr_nxt;
  logic                   valid_nxt, done_nxt;
  logic                   fetch, redirect, halt_fetch, last_fetch;

  assign imem_addr = pc;

`ifdef INSTR_FETCH_BRANCH_LUT_EN
  logic [PC_WIDTH-1:0] lut [16];

  // NOTE: the table must clear on reset, so it is built from flops rather than inferred as RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) lut[i] <= '0;
    end else if (lut_we && state != RUN) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  assign target = lut[target_idx];
`else
  logic unused_lut;
  assign unused_lut = ^{lut_we, lut_waddr, lut_wdata};

  assign target = pc_out + {{(PC_WIDTH-4){target_idx[3]}}, target_idx};
`endif

  // A redirect needs a valid word in flight; a branch beats the halt word and the top-of-memory stop.
  assign fetch      = (state == RUN) && !stall;
  assign redirect   = fetch && branch_taken && instr_valid;
  assign halt_fetch = fetch && !redirect && (imem_data == HALT_WORD);
  assign last_fetch = fetch && !redirect && !halt_fetch && (pc == {PC_WIDTH{1'b1}});

  // NOTE: registers update with <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt_fetch || last_fetch) state_nxt = HALT;
      HALT:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output starts from its hold value so no path through the case leaves a latch.
  always_comb begin
    pc_nxt     = pc;
    instr_nxt  = instr;
    pc_out_nxt = pc_out;
    valid_nxt  = instr_valid;
    done_nxt   = done;
    case (state)
      IDLE: if (start) pc_nxt = '0;
      RUN: if (!stall) begin
        if (redirect) begin
          pc_nxt    = target;
          valid_nxt = 1'b0;
        end else if (halt_fetch) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          instr_nxt  = imem_data;
          pc_out_nxt = pc;
          valid_nxt  = 1'b1;
          if (last_fetch) done_nxt = 1'b1;
          else            pc_nxt   = pc + PC_WIDTH'(1);
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
        if (start) begin
          done_nxt = 1'b0;
          pc_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      pc_out      <= pc_out_nxt;
      instr_valid <= valid_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs push expected {instr, pc_out};
// a negedge monitor pops and compares each newly presented word.
module tb_instr_fetch;
  localparam int PW = 10;
  localparam int IW = 9;
  localparam logic [IW-1:0] HW = 9'h1FF;

  logic          clk, reset, start, stall, branch_taken, lut_we;
  logic [3:0]    target_idx, lut_waddr;
  logic [PW-1:0] lut_wdata, imem_addr, pc_out;
  logic [IW-1:0] imem_data, instr;
  logic          instr_valid, done;

  logic [IW-1:0] mem [1024];
  assign imem_data = mem[imem_addr];

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .target_idx(target_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0, sb_errors = 0, sb_checks = 0;
  logic [IW+PW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] w, input logic [PW-1:0] a);
    exp_q.push_back({w, a});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done !== 1'b1; i++) tick();
    check("done_reached", done, 1);
  endtask

  // Monitor: a word is new when valid rises or pc_out moves while valid.
  logic          prev_valid = 1'b0;
  logic [PW-1:0] prev_pc    = '0;
  logic [IW+PW-1:0] exp_e;
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && (!prev_valid || pc_out != prev_pc)) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        sb_errors++;
        $display("FAIL sb_unexpected: got instr=%0h pc_out=%0h expected no word", instr, pc_out);
      end else begin
        exp_e = exp_q.pop_front();
        if ({instr, pc_out} !== exp_e) begin
          sb_errors++;
          $display("FAIL sb_word: got instr=%0h pc_out=%0h expected instr=%0h pc_out=%0h",
                   instr, pc_out, exp_e[IW+PW-1:PW], exp_e[PW-1:0]);
        end
      end
    end
    prev_valid = (instr_valid === 1'b1);
    prev_pc    = pc_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    target_idx = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    tick(); tick();
    check("rst_instr", instr, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_done", done, 0);
    check("rst_addr", imem_addr, 0);
    reset = 1'b0;

    // Straight-line program ending in the halt word
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h004; mem[4] = HW;
    push(9'h001, 0); push(9'h002, 1); push(9'h003, 2); push(9'h004, 3);
    pulse_start();
    check("start_addr", imem_addr, 0);
    check("start_valid", instr_valid, 0);
    wait_done(20);
    check("halt_valid", instr_valid, 0);
    check("halt_addr", imem_addr, 4);
    tick(); tick(); tick();
    check("halt_hold_done", done, 1);
    check("halt_hold_addr", imem_addr, 4);
    check("q_empty_seq", exp_q.size(), 0);

    // Stall for three cycles at pc=2
    for (int i = 0; i < 6; i++) mem[i] = IW'(9'h010 + i);
    mem[6] = HW;
    for (int i = 0; i < 6; i++) push(IW'(9'h010 + i), PW'(i));
    pulse_start();
    check("restart_done_clr", done, 0);
    for (int i = 0; i < 10 && imem_addr != 2; i++) tick();
    check("stall_reach_pc2", imem_addr, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_instr", instr, 9'h011);
      check("stall_pc_out", pc_out, 1);
      check("stall_valid", instr_valid, 1);
      check("stall_addr", imem_addr, 2);
    end
    stall = 1'b0;
    wait_done(20);
    check("stall_end_addr", imem_addr, 6);
    check("q_empty_stall", exp_q.size(), 0);

    // Relative branch -2 from pc_out=10, first held off by stall
    for (int i = 0; i < 16; i++) mem[i] = IW'(9'h020 + i);
    mem[16] = HW;
    for (int i = 0; i <= 10; i++) push(IW'(9'h020 + i), PW'(i));
`ifndef INSTR_FETCH_BRANCH_LUT_EN
    for (int i = 8; i <= 15; i++) push(IW'(9'h020 + i), PW'(i));
`endif
    pulse_start();
    for (int i = 0; i < 20 && !(instr_valid === 1'b1 && pc_out == 10); i++) tick();
    check("br_reach_pc10", pc_out, 10);
`ifndef INSTR_FETCH_BRANCH_LUT_EN
    stall = 1'b1; branch_taken = 1'b1; target_idx = 4'b1110;
    tick(); tick();
    check("br_stalled_addr", imem_addr, 11);
    check("br_stalled_pc_out", pc_out, 10);
    stall = 1'b0;
    tick();
    check("br_flush_valid", instr_valid, 0);
    check("br_target_addr", imem_addr, 8);
    tick();
    check("br_ignored_addr", imem_addr, 9);
    check("br_first_pc_out", pc_out, 8);
    branch_taken = 1'b0; target_idx = '0;
`endif
    wait_done(40);
    check("q_empty_branch", exp_q.size(), 0);

    // Reset in the middle of RUN while stalled
    for (int i = 0; i <= 6; i++) push(IW'(9'h020 + i), PW'(i));
    pulse_start();
    for (int i = 0; i < 20 && imem_addr != 7; i++) tick();
    check("mid_reach_pc7", imem_addr, 7);
    reset = 1'b1; stall = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    check("mid_rst_instr", instr, 0);
    check("mid_rst_pc_out", pc_out, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", imem_addr, 0);
    branch_taken = 1'b1;
    tick(); tick();
    branch_taken = 1'b0;
    check("idle_addr", imem_addr, 0);
    check("idle_valid", instr_valid, 0);
    check("q_empty_reset", exp_q.size(), 0);

`ifdef INSTR_FETCH_BRANCH_LUT_EN
    // Table branch: table[5]=0x040 written in IDLE, taken at pc_out=3
    lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 10'h040;
    tick();
    lut_we = 1'b0;
    mem[10'h040] = 9'h055; mem[10'h041] = HW;
    for (int i = 0; i <= 3; i++) push(IW'(9'h020 + i), PW'(i));
    push(9'h055, 10'h040);
    pulse_start();
    for (int i = 0; i < 20 && !(instr_valid === 1'b1 && pc_out == 3); i++) tick();
    check("lut_reach_pc3", pc_out, 3);
    branch_taken = 1'b1; target_idx = 4'd5;
    tick();
    branch_taken = 1'b0; target_idx = '0;
    check("lut_flush_valid", instr_valid, 0);
    check("lut_target_addr", imem_addr, 10'h040);
    wait_done(20);
    check("q_empty_lut", exp_q.size(), 0);
`endif

    // Run to the top of memory: must stop without wrapping
    for (int i = 0; i < 1024; i++) mem[i] = IW'(i % 256);
    for (int i = 0; i < 1024; i++) push(IW'(i % 256), PW'(i));
    pulse_start();
    wait_done(1100);
    check("top_addr", imem_addr, 1023);
    check("top_pc_out", pc_out, 1023);
    check("top_instr", instr, 9'h0FF);
    tick();
    check("top_valid_drop", instr_valid, 0);
    check("top_no_wrap", imem_addr, 1023);
    check("top_done_hold", done, 1);
    check("q_empty_top", exp_q.size(), 0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors + sb_errors, checks + sb_checks);
    $finish;
  end
endmodule
